// File: rtl/latch_write_arbiter_pkg.sv
// Shared definitions for the latch write arbiter: FSM state codes and the
// round-robin pick function used by rr_arbiter.
package latch_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_OPEN  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int unsigned RR_MAXN = 32'd32;
  localparam int          RR_IW   = $clog2(RR_MAXN);

  // Fixed-width pick so one function serves any NREQ up to RR_MAXN; only the
  // low n bits of req are searched, starting at ptr and wrapping modulo n.
  function automatic logic [RR_MAXN-1:0] rr_pick(input logic [RR_MAXN-1:0] req,
                                                 input int unsigned n,
                                                 input int unsigned ptr);
    logic [RR_MAXN-1:0] pick;
    logic               found;
    logic [RR_IW-1:0]   idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 32'd0; k < RR_MAXN; k++) begin
      idx = RR_IW'((ptr + k) % n);
      if ((k < n) && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/latch_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick plus the rotating priority
// pointer, which advances past the winner only when en (grant) is high.
module rr_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] pick
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      ptr_d;
  logic [RR_MAXN-1:0] req_ext;
  logic [RR_MAXN-1:0] pick_ext;

  // Winner selection and pointer advance to the slot after the winner
  always_comb begin
    req_ext             = '0;
    req_ext[NREQ-1:0]   = req;
    pick_ext            = rr_pick(req_ext, NREQ, 32'(ptr_q));
    pick                = pick_ext[NREQ-1:0];
    ptr_d               = ptr_q;
    if (en) begin
      for (int i = 0; i < NREQ; i++) begin
        ptr_d = pick[i] ? PW'((i + 1) % NREQ) : ptr_d;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// Arbitrates NREQ writers onto one transparent latch word and sequences its
// d/en pins through SETUP, OPEN and HOLD, then checks q on completion.
module latch_write_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic                  busy,
  output logic [WIDTH-1:0]      latch_d,
  output logic                  latch_en,
  input  logic [WIDTH-1:0]      latch_q
);

  localparam int MAXC_SE = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
  localparam int MAXC    = (MAXC_SE > HOLD_CYC) ? MAXC_SE : HOLD_CYC;
  localparam int CW      = $clog2(MAXC + 1);

  typedef logic [CW-1:0] cnt_t;

  // Counter reload values are "cycles - 1"; a phase ends when the count hits zero.
  localparam cnt_t SETUP_LD   = cnt_t'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam cnt_t OPEN_LD    = cnt_t'(EN_CYC - 1);
  localparam cnt_t HOLD_LD    = cnt_t'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [2:0] FIRST_ST   = (SETUP_CYC > 0) ? ST_SETUP : ST_OPEN;
  localparam cnt_t       FIRST_LD   = (SETUP_CYC > 0) ? SETUP_LD : OPEN_LD;
  localparam logic [2:0] AFTER_OPEN = (HOLD_CYC > 0) ? ST_HOLD : ST_DONE;

  logic [2:0]       state_q, state_d;
  cnt_t             cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] wd_q, wd_d;
  logic             en_q;
  logic [NREQ-1:0]  done_q;
  logic             busy_q;
  logic [NREQ-1:0]  pick;
  logic [WIDTH-1:0] wdata;
  logic             start;

  assign start = (state_q == ST_IDLE) && (|req);

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .en   (start),
    .pick (pick)
  );

  // Mux the winner's data word using the one-hot pick
  always_comb begin
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      wdata = pick[i] ? (wdata | data_in[i*WIDTH +: WIDTH]) : wdata;
    end
  end

  // Next-state, phase counter and grant/data capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    wd_d    = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = FIRST_ST;
          cnt_d   = FIRST_LD;
          gnt_d   = pick;
          wd_d    = wdata;
        end else begin
          gnt_d = '0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_OPEN;
          cnt_d   = OPEN_LD;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ST_OPEN: begin
        if (cnt_q == '0) begin
          state_d = AFTER_OPEN;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        gnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        gnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; en/done/busy are decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      wd_q    <= '0;
      en_q    <= 1'b0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      wd_q    <= wd_d;
      en_q    <= (state_d == ST_OPEN);
      done_q  <= (state_d == ST_DONE) ? gnt_d : '0;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Readback compare must see latch_q in the DONE cycle itself
  assign err      = (state_q == ST_DONE) && (latch_q != wd_q);
  assign gnt      = gnt_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign latch_d  = wd_q;
  assign latch_en = en_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Self-checking bench: randomized writes against a transaction-level model
// (round-robin by modular search, timing from phase lengths, latch behaviour).
module tb_latch_write_arbiter;

  localparam int S = 1;
  localparam int E = 2;
  localparam int H = 1;
  localparam int T = S + E + H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0;
  logic [31:0] data_in = 32'h0;
  logic [3:0]  gnt, done;
  logic        err, busy, latch_en;
  logic [7:0]  latch_d;
  logic [7:0]  lq = 8'h00;
  logic        stuck = 1'b0;

  logic [3:0]  req6 = 4'b0;
  logic [31:0] data6 = 32'h0;
  logic [3:0]  gnt6, done6;
  logic        err6, busy6, en6;
  logic [7:0]  ld6;
  logic [7:0]  lq6 = 8'h00;

  int n_cmp = 0;
  int n_fail = 0;
  int ptr_m = 0;
  int ptr6_m = 0;

  always #5 clk = ~clk;

  latch_write_arbiter #(.NREQ(4), .WIDTH(8), .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .gnt(gnt), .done(done),
    .err(err), .busy(busy), .latch_d(latch_d), .latch_en(latch_en), .latch_q(lq));

  latch_write_arbiter #(.NREQ(4), .WIDTH(8), .SETUP_CYC(0), .EN_CYC(1), .HOLD_CYC(0)) dut6 (
    .clk(clk), .rst(rst), .req(req6), .data_in(data6), .gnt(gnt6), .done(done6),
    .err(err6), .busy(busy6), .latch_d(ld6), .latch_en(en6), .latch_q(lq6));

  // Transparent latch models (one can be forced stuck at zero)
  always @(latch_en or latch_d or stuck) begin
    if (stuck) lq = 8'h00;
    else if (latch_en) lq = latch_d;
  end
  always @(en6 or ld6) begin
    if (en6) lq6 = ld6;
  end

  function automatic int model_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (gnt !== 4'b0)    begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    n_cmp++; if (done !== 4'b0)   begin n_fail++; $display("FAIL reset_done got=%b exp=0000", done); end
    n_cmp++; if (busy !== 1'b0 || err !== 1'b0 || latch_en !== 1'b0)
      begin n_fail++; $display("FAIL reset_flags busy=%b err=%b en=%b exp=000", busy, err, latch_en); end
    n_cmp++; if (latch_d !== 8'h00) begin n_fail++; $display("FAIL reset_latch_d got=%h exp=00", latch_d); end
    rst = 1'b0;
    ptr_m = 0;
    ptr6_m = 0;
  endtask

  task automatic test_round_robin();
    bit found;
    int w, exp;
    logic [3:0] g;
    data_in = $urandom;
    req = 4'b1111;
    for (int tx = 0; tx < 5; tx++) begin
      found = 0; w = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (gnt !== 4'b0) begin found = 1; w = k + 1; break; end
      end
      n_cmp++; if (!found) begin n_fail++; $display("FAIL rr_gnt_timeout tx=%0d", tx); end
      exp = model_pick(req, ptr_m);
      ptr_m = (exp + 1) % 4;
      n_cmp++; if (gnt !== (4'b1 << exp)) begin n_fail++; $display("FAIL rr_order tx=%0d got=%b exp=%b", tx, gnt, 4'b1 << exp); end
      n_cmp++; if (latch_d !== data_in[exp*8 +: 8]) begin n_fail++; $display("FAIL rr_data got=%h exp=%h", latch_d, data_in[exp*8 +: 8]); end
      if (tx > 0) begin
        n_cmp++; if (w !== 2) begin n_fail++; $display("FAIL rr_gap got=%0d exp=2", w); end
      end
      if (tx == 4) req = 4'b0;
      g = gnt; found = 0; w = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (done !== 4'b0) begin found = 1; w = k + 1; break; end
      end
      n_cmp++; if (!found || w !== T) begin n_fail++; $display("FAIL rr_latency got=%0d exp=%0d", w, T); end
      n_cmp++; if (done !== g || err !== 1'b0) begin n_fail++; $display("FAIL rr_done done=%b err=%b exp=%b/0", done, err, g); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    logic [3:0] eg, ed;
    logic ee, eb;
    data_in = $urandom;
    data_in[15:8] = 8'hA5;
    req = 4'b0010;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      eg = (c <= T) ? 4'b0010 : 4'b0;
      ed = (c == T) ? 4'b0010 : 4'b0;
      ee = (c >= S) && (c < S + E);
      eb = (c <= T);
      n_cmp++; if (gnt !== eg) begin n_fail++; $display("FAIL single_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
      n_cmp++; if (latch_en !== ee) begin n_fail++; $display("FAIL single_en c=%0d got=%b exp=%b", c, latch_en, ee); end
      n_cmp++; if (done !== ed || err !== 1'b0) begin n_fail++; $display("FAIL single_done c=%0d got=%b/%b exp=%b/0", c, done, err, ed); end
      n_cmp++; if (busy !== eb) begin n_fail++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy, eb); end
      n_cmp++; if (latch_d !== 8'hA5) begin n_fail++; $display("FAIL single_d c=%0d got=%h exp=a5", c, latch_d); end
      if (c == 0) req = 4'b0;
    end
    ptr_m = 2;
  endtask

  task automatic test_err();
    int r, exp;
    bit found;
    r = $urandom_range(0, 3);
    stuck = 1'b1;
    data_in = $urandom;
    data_in[r*8 +: 8] = 8'h3C;
    req = 4'b1 << r;
    exp = model_pick(req, ptr_m);
    ptr_m = (exp + 1) % 4;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt !== 4'b0) req = 4'b0;
      if (done !== 4'b0) begin found = 1; break; end
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL err_done_timeout"); end
    n_cmp++; if (err !== 1'b1 || done !== (4'b1 << exp)) begin n_fail++; $display("FAIL err_pulse err=%b done=%b exp=1/%b", err, done, 4'b1 << exp); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b0 || done !== 4'b0) begin n_fail++; $display("FAIL err_after err=%b done=%b exp=0/0000", err, done); end
    stuck = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_drop();
    logic [7:0] cap;
    bit fg, fe, fd;
    cap = 8'($urandom_range(0, 254));
    data_in = $urandom;
    data_in[23:16] = cap;
    req = 4'b0100;
    ptr_m = 3;
    fg = 0; fe = 0; fd = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt !== 4'b0) begin req = 4'b0; fg = 1; end
      if (latch_en === 1'b1) begin data_in[23:16] = 8'hFF; fe = 1; end
      if (done !== 4'b0) begin fd = 1; break; end
    end
    n_cmp++; if (!(fg && fe && fd)) begin n_fail++; $display("FAIL drop_timeout g=%b e=%b d=%b", fg, fe, fd); end
    n_cmp++; if (done !== 4'b0100) begin n_fail++; $display("FAIL drop_done got=%b exp=0100", done); end
    n_cmp++; if (latch_d !== cap || lq !== cap) begin n_fail++; $display("FAIL drop_value d=%h q=%h exp=%h", latch_d, lq, cap); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL drop_err got=%b exp=0", err); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [7:0] last_d, wd;
    int exp;
    bit found;
    last_d = latch_d;
    for (int it = 0; it < 25; it++) begin
      r = 4'($urandom_range(0, 15));
      data_in = $urandom;
      req = r;
      if (r == 4'b0) begin
        repeat (3) begin
          @(negedge clk);
          n_cmp++; if (busy !== 1'b0 || gnt !== 4'b0 || latch_d !== last_d)
            begin n_fail++; $display("FAIL rnd_idle busy=%b gnt=%b d=%h exp=0/0000/%h", busy, gnt, latch_d, last_d); end
        end
      end else begin
        exp = model_pick(r, ptr_m);
        ptr_m = (exp + 1) % 4;
        wd = data_in[exp*8 +: 8];
        found = 0;
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (gnt !== 4'b0) begin found = 1; break; end
        end
        n_cmp++; if (!found || gnt !== (4'b1 << exp)) begin n_fail++; $display("FAIL rnd_gnt got=%b exp=%b", gnt, 4'b1 << exp); end
        req = 4'($urandom_range(0, 15));
        data_in = $urandom;
        found = 0;
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          if (done !== 4'b0) begin found = 1; break; end
        end
        n_cmp++; if (!found || done !== (4'b1 << exp) || err !== 1'b0 || latch_d !== wd)
          begin n_fail++; $display("FAIL rnd_done done=%b err=%b d=%h exp=%b/0/%h", done, err, latch_d, 4'b1 << exp, wd); end
        req = 4'b0;
        @(negedge clk);
        if (gnt !== 4'b0) begin
          exp = model_pick(4'b0, ptr_m);
        end
        last_d = wd;
        repeat (2) @(negedge clk);
        if (busy === 1'b1) begin
          for (int k = 0; k < 10; k++) begin
            if (busy !== 1'b1) break;
            @(negedge clk);
          end
        end
        last_d = latch_d;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found, seen_done;
    data_in = $urandom;
    req = 4'b1000;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (latch_en === 1'b1) begin found = 1; break; end
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL rstmid_open_timeout"); end
    rst = 1'b1;
    req = 4'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++; if (latch_en !== 1'b0 || gnt !== 4'b0 || done !== 4'b0 || busy !== 1'b0 || err !== 1'b0 || latch_d !== 8'h00)
        begin n_fail++; $display("FAIL rstmid_outputs c=%0d en=%b gnt=%b done=%b busy=%b err=%b d=%h exp=all zero", c, latch_en, gnt, done, busy, err, latch_d); end
    end
    rst = 1'b0;
    ptr_m = 0;
    ptr6_m = 0;
    seen_done = 0;
    repeat (6) begin
      @(negedge clk);
      if (done !== 4'b0 || busy !== 1'b0) seen_done = 1;
    end
    n_cmp++; if (seen_done) begin n_fail++; $display("FAIL rstmid_no_done got=1 exp=0"); end
  endtask

  task automatic test_short();
    logic [3:0] r;
    int exp;
    bit found;
    for (int it = 0; it < 3; it++) begin
      r = 4'($urandom_range(1, 15));
      data6 = $urandom;
      req6 = r;
      exp = model_pick(r, ptr6_m);
      ptr6_m = (exp + 1) % 4;
      found = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (gnt6 !== 4'b0) begin found = 1; break; end
      end
      req6 = 4'b0;
      n_cmp++; if (!found || gnt6 !== (4'b1 << exp) || en6 !== 1'b1 || done6 !== 4'b0)
        begin n_fail++; $display("FAIL short_c0 gnt=%b en=%b done=%b exp=%b/1/0000", gnt6, en6, done6, 4'b1 << exp); end
      @(negedge clk);
      n_cmp++; if (done6 !== (4'b1 << exp) || en6 !== 1'b0 || err6 !== 1'b0 || ld6 !== data6[exp*8 +: 8])
        begin n_fail++; $display("FAIL short_c1 done=%b en=%b err=%b d=%h exp=%b/0/0/%h", done6, en6, err6, ld6, 4'b1 << exp, data6[exp*8 +: 8]); end
      @(negedge clk);
      n_cmp++; if (busy6 !== 1'b0 || gnt6 !== 4'b0) begin n_fail++; $display("FAIL short_c2 busy=%b gnt=%b exp=0/0000", busy6, gnt6); end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_err();
    test_drop();
    test_random();
    test_reset_mid();
    test_short();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
